// File: rtl/istisna_denetleyici_pkg.sv
// Shared constants and FSM state type for the machine-mode trap sequencer.
// Holds the CSR addresses, mstatus bit positions, cause codes and state encodings.
package istisna_denetleyici_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int KOD_ATLAMA_HIZA = 0;
    localparam int KOD_GECERSIZ    = 2;
    localparam int KOD_EBREAK      = 3;
    localparam int KOD_YUKLE_HIZA  = 4;
    localparam int KOD_SAKLA_HIZA  = 6;
    localparam int KOD_ECALL       = 11;

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        EPC_YAZ   = 3'd1,
        CAUSE_YAZ = 3'd2,
        STAT_YAZ  = 3'd3,
        ATLA      = 3'd4,
        RET_YAZ   = 3'd5,
        RET_ATLA  = 3'd6
    } durum_t;

endpackage

// File: rtl/istisna_denetleyici_if.sv
// Trap request, CSR read/write and fetch redirect signals of the trap sequencer.
// master is the sequencer side; slave is the pipeline / CSR unit side.
interface istisna_denetleyici_if #(
    parameter int KOD_W = 4
);
    logic             istisna_i;
    logic [KOD_W-1:0] istisna_kod_i;
    logic [30:0]      istisna_ps_i;
    logic             mret_i;
    logic [31:0]      mstatus_i;
    logic [31:0]      mtvec_i;
    logic [31:0]      mepc_i;
    logic             csr_yaz_o;
    logic [11:0]      csr_adr_o;
    logic [31:0]      csr_deger_o;
    logic             durdur_o;
    logic             bosalt_o;
    logic             yonlendir_o;
    logic [30:0]      yonlendir_ps_o;

    modport master (
        input  istisna_i, istisna_kod_i, istisna_ps_i, mret_i,
        input  mstatus_i, mtvec_i, mepc_i,
        output csr_yaz_o, csr_adr_o, csr_deger_o,
        output durdur_o, bosalt_o, yonlendir_o, yonlendir_ps_o
    );

    modport slave (
        output istisna_i, istisna_kod_i, istisna_ps_i, mret_i,
        output mstatus_i, mtvec_i, mepc_i,
        input  csr_yaz_o, csr_adr_o, csr_deger_o,
        input  durdur_o, bosalt_o, yonlendir_o, yonlendir_ps_o
    );

endinterface

// File: rtl/istisna_denetleyici.sv
// Trap sequencer: writes mepc/mcause/mstatus on an exception, restores mstatus on
// mret, stalls the pipeline meanwhile and redirects fetch with a one-cycle flush.
module istisna_denetleyici
    import istisna_denetleyici_pkg::*;
#(
    parameter int         KOD_W      = 4,
    parameter logic [1:0] MPP_DEGERI = 2'b11
) (
    input logic                 clk_i,
    input logic                 rst_i,
    istisna_denetleyici_if.master bus
);

    durum_t           durum_q;
    durum_t           durum_d;
    logic [KOD_W-1:0] kod_q;
    logic [30:0]      ps_q;
    logic [31:0]      mstatus_q;
    logic [30:0]      hedef_q;
    logic [31:0]      stat_istisna;
    logic [31:0]      stat_donus;
    logic             kabul;
    logic             unused_bitler;

    assign kabul = (durum_q == BOSTA) && (bus.istisna_i || bus.mret_i);

    // mtvec mode bits and mepc[0] never reach the redirect target.
    assign unused_bitler = ^{bus.mtvec_i[1:0], bus.mepc_i[0]};

    // Target is latched one cycle before the jump so no input reaches an output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q   <= BOSTA;
            kod_q     <= '0;
            ps_q      <= '0;
            mstatus_q <= '0;
            hedef_q   <= '0;
        end else begin
            durum_q <= durum_d;
            if (kabul) begin
                kod_q     <= bus.istisna_kod_i;
                ps_q      <= bus.istisna_ps_i;
                mstatus_q <= bus.mstatus_i;
            end
            if (durum_q == STAT_YAZ) begin
                hedef_q <= {bus.mtvec_i[31:2], 1'b0};
            end else if (durum_q == RET_YAZ) begin
                hedef_q <= bus.mepc_i[31:1];
            end
        end
    end

    always_comb begin
        stat_istisna = mstatus_q;
        stat_istisna[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
        stat_istisna[MSTATUS_MIE]  = 1'b0;
        stat_istisna[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_DEGERI;

        stat_donus = mstatus_q;
        stat_donus[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
        stat_donus[MSTATUS_MPIE] = 1'b1;
    end

    always_comb begin
        durum_d            = durum_q;
        bus.csr_yaz_o      = 1'b0;
        bus.csr_adr_o      = '0;
        bus.csr_deger_o    = '0;
        bus.durdur_o       = 1'b1;
        bus.bosalt_o       = 1'b0;
        bus.yonlendir_o    = 1'b0;
        bus.yonlendir_ps_o = '0;
        unique case (durum_q)
            BOSTA: begin
                bus.durdur_o = 1'b0;
                if (bus.istisna_i) begin
                    durum_d = EPC_YAZ;
                end else if (bus.mret_i) begin
                    durum_d = RET_YAZ;
                end
            end
            EPC_YAZ: begin
                bus.csr_yaz_o   = 1'b1;
                bus.csr_adr_o   = CSR_MEPC;
                bus.csr_deger_o = {ps_q, 1'b0};
                durum_d         = CAUSE_YAZ;
            end
            CAUSE_YAZ: begin
                bus.csr_yaz_o   = 1'b1;
                bus.csr_adr_o   = CSR_MCAUSE;
                bus.csr_deger_o = 32'(kod_q);
                durum_d         = STAT_YAZ;
            end
            STAT_YAZ: begin
                bus.csr_yaz_o   = 1'b1;
                bus.csr_adr_o   = CSR_MSTATUS;
                bus.csr_deger_o = stat_istisna;
                durum_d         = ATLA;
            end
            ATLA: begin
                bus.bosalt_o       = 1'b1;
                bus.yonlendir_o    = 1'b1;
                bus.yonlendir_ps_o = hedef_q;
                durum_d            = BOSTA;
            end
            RET_YAZ: begin
                bus.csr_yaz_o   = 1'b1;
                bus.csr_adr_o   = CSR_MSTATUS;
                bus.csr_deger_o = stat_donus;
                durum_d         = RET_ATLA;
            end
            RET_ATLA: begin
                bus.bosalt_o       = 1'b1;
                bus.yonlendir_o    = 1'b1;
                bus.yonlendir_ps_o = hedef_q;
                durum_d            = BOSTA;
            end
            default: begin
                bus.durdur_o = 1'b0;
                durum_d      = BOSTA;
            end
        endcase
    end

endmodule

// File: tb/tb_istisna_denetleyici.sv
// Scoreboard bench for istisna_denetleyici: directed traps and mrets push expected
// CSR writes and redirects; a negedge monitor pops and compares them.
module tb_istisna_denetleyici;

    typedef struct {
        int          cyc;
        logic [11:0] adr;
        logic [31:0] deger;
    } yaz_t;

    typedef struct {
        int          cyc;
        logic [30:0] ps;
    } yon_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   cyc = 0;
    int   toplam = 0;
    int   gecen = 0;
    int   durdur_n = 0;
    int   durdur_bek = 0;
    yaz_t yaz_q[$];
    yon_t yon_q[$];

    istisna_denetleyici_if #(.KOD_W(4)) bus ();

    istisna_denetleyici #(
        .KOD_W(4),
        .MPP_DEGERI(2'b11)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus.master)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic tik(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic sifir_kontrol(input string ad);
        logic [78:0] v;
        v = {bus.csr_yaz_o, bus.csr_adr_o, bus.csr_deger_o, bus.durdur_o,
             bus.bosalt_o, bus.yonlendir_o, bus.yonlendir_ps_o};
        toplam++;
        if (v == '0) gecen++;
        else $display("FAIL %s: outputs=%h required 0", ad, v);
    endtask

    // tam=0: only the mepc and mcause writes are expected (sequence cut by reset)
    task automatic istisna(input logic [3:0] kod, input logic [30:0] ps,
                           input logic [31:0] mst, input logic [31:0] bek_stat,
                           input logic [30:0] bek_hedef, input logic ayni_mret,
                           input bit tam);
        int c;
        c = cyc;
        bus.istisna_i     = 1'b1;
        bus.istisna_kod_i = kod;
        bus.istisna_ps_i  = ps;
        bus.mstatus_i     = mst;
        bus.mret_i        = ayni_mret;
        yaz_q.push_back('{c + 1, 12'h341, {ps, 1'b0}});
        yaz_q.push_back('{c + 2, 12'h342, {28'h0, kod}});
        if (tam) begin
            yaz_q.push_back('{c + 3, 12'h300, bek_stat});
            yon_q.push_back('{c + 4, bek_hedef});
            durdur_bek += 4;
        end else begin
            durdur_bek += 2;
        end
        tik(1);
        bus.istisna_i = 1'b0;
        bus.mret_i    = 1'b0;
        bus.mstatus_i = 32'hDEAD_BEEF;
    endtask

    task automatic mret(input logic [31:0] mst, input logic [31:0] mepc,
                        input logic [31:0] bek_stat, input logic [30:0] bek_hedef);
        int c;
        c = cyc;
        bus.mret_i    = 1'b1;
        bus.mstatus_i = mst;
        bus.mepc_i    = mepc;
        yaz_q.push_back('{c + 1, 12'h300, bek_stat});
        yon_q.push_back('{c + 2, bek_hedef});
        durdur_bek += 2;
        tik(1);
        bus.mret_i    = 1'b0;
        bus.mstatus_i = 32'hDEAD_BEEF;
    endtask

    always @(negedge clk_i) begin
        yaz_t w;
        yon_t y;
        if (bus.durdur_o) durdur_n++;
        if (bus.csr_yaz_o) begin
            toplam++;
            if (yaz_q.size() == 0) begin
                $display("FAIL csr_write: unexpected adr=%h data=%h cyc=%0d",
                         bus.csr_adr_o, bus.csr_deger_o, cyc);
            end else begin
                w = yaz_q.pop_front();
                if (w.cyc == cyc && w.adr == bus.csr_adr_o && w.deger == bus.csr_deger_o)
                    gecen++;
                else
                    $display("FAIL csr_write: got adr=%h data=%h cyc=%0d required adr=%h data=%h cyc=%0d",
                             bus.csr_adr_o, bus.csr_deger_o, cyc, w.adr, w.deger, w.cyc);
            end
        end
        if (bus.yonlendir_o || bus.bosalt_o) begin
            toplam++;
            if (yon_q.size() == 0) begin
                $display("FAIL redirect: unexpected ps=%h flush=%b cyc=%0d",
                         bus.yonlendir_ps_o, bus.bosalt_o, cyc);
            end else begin
                y = yon_q.pop_front();
                if (y.cyc == cyc && y.ps == bus.yonlendir_ps_o && bus.bosalt_o && bus.yonlendir_o)
                    gecen++;
                else
                    $display("FAIL redirect: got ps=%h flush=%b valid=%b cyc=%0d required ps=%h cyc=%0d",
                             bus.yonlendir_ps_o, bus.bosalt_o, bus.yonlendir_o, cyc, y.ps, y.cyc);
            end
        end
    end

    initial begin
        bus.istisna_i     = 1'b0;
        bus.istisna_kod_i = '0;
        bus.istisna_ps_i  = '0;
        bus.mret_i        = 1'b0;
        bus.mstatus_i     = '0;
        bus.mtvec_i       = 32'h0000_1001;
        bus.mepc_i        = '0;
        rst_i = 1'b1;
        tik(3);
        sifir_kontrol("reset_state");
        rst_i = 1'b0;
        tik(2);

        // ecall
        istisna(4'd11, 31'h40, 32'h8, 32'h1880, 31'h800, 1'b0, 1'b1);
        tik(5);

        // mret restoring MIE from MPIE
        mret(32'h1880, 32'h84, 32'h1888, 31'h42);
        tik(3);

        // mret with MPIE clear
        mret(32'h1800, 32'h200, 32'h1880, 31'h100);
        tik(3);

        // exception and mret together: exception wins
        bus.mtvec_i = 32'h0000_2000;
        istisna(4'd2, 31'h100, 32'h0, 32'h1800, 31'h1000, 1'b1, 1'b1);
        tik(5);

        // second exception pulse mid-sequence is ignored
        istisna(4'd4, 31'h50, 32'h88, 32'h1880, 31'h1000, 1'b0, 1'b1);
        tik(1);
        bus.istisna_i     = 1'b1;
        bus.istisna_kod_i = 4'd6;
        bus.istisna_ps_i  = 31'h77;
        tik(1);
        bus.istisna_i = 1'b0;
        tik(4);

        // reset while writing mcause
        istisna(4'd3, 31'h10, 32'h8, 32'h0, 31'h0, 1'b0, 1'b0);
        tik(1);
        rst_i = 1'b1;
        tik(1);
        sifir_kontrol("mid_reset");
        rst_i = 1'b0;
        tik(3);

        // back-to-back: new exception in the cycle after ATLA
        bus.mtvec_i = 32'h0000_1001;
        istisna(4'd11, 31'h20, 32'h8, 32'h1880, 31'h800, 1'b0, 1'b1);
        tik(4);
        istisna(4'd0, 31'h30, 32'h1800, 32'h1800, 31'h800, 1'b0, 1'b1);
        tik(8);

        toplam++;
        if (yaz_q.size() == 0) gecen++;
        else $display("FAIL missing_writes: pending=%0d required 0", yaz_q.size());
        toplam++;
        if (yon_q.size() == 0) gecen++;
        else $display("FAIL missing_redirects: pending=%0d required 0", yon_q.size());
        toplam++;
        if (durdur_n == durdur_bek) gecen++;
        else $display("FAIL stall_cycles: got %0d required %0d", durdur_n, durdur_bek);

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule
